// File: rtl/rr_mux_n_pkg.sv
// Shared constants and helpers for the arbitrated N:1 handshake mux.
// Latency: n/a (constants and constant functions only).
// Backpressure: n/a.
package rr_mux_n_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Ceiling log2 with a floor of 1, so a select field is never zero bits wide.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_mux_n_arbiter.sv
// Request arbiter: fixed priority (lowest index) or round-robin starting at ptr.
// Latency: purely combinational.
// Backpressure: none; grant is a pure function of req and ptr.
module rr_arbiter
    import rr_mux_n_pkg::*;
#(
    parameter int N        = 4,
    parameter int ARB_MODE = ARB_RR,
    parameter int SELW     = clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] grant_idx
);

    // Scan N slots starting at the priority origin; the first requester wins.
    // The origin is 0 in fixed mode. Wrapping is by N, so indices >= N are never produced.
    always_comb begin
        int start;
        int idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        start     = (ARB_MODE == ARB_RR) ? int'(ptr) : 0;
        if (start >= N) begin
            start = start - N;
        end
        for (int i = 0; i < N; i++) begin
            idx = start + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = SELW'(idx);
            end
        end
    end

endmodule

// File: rtl/rr_mux_n.sv
// N-input W-bit arbitrated mux with valid/ready on every port and a registered output.
// Latency: a beat accepted in cycle t is presented with out_valid in cycle t+1.
// Backpressure: in_ready drops to zero while the output holds an unaccepted beat; the output drains and reloads in the same cycle.
module rr_mux_n
    import rr_mux_n_pkg::*;
#(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int ARB_MODE = ARB_RR,
    parameter int SELW     = clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N*W-1:0]    in_data,
    input  logic [N-1:0]      in_valid,
    output logic [N-1:0]      in_ready,
    output logic [W-1:0]      out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SELW-1:0]   out_sel
);

    logic [W-1:0]    out_data_q,  out_data_d;
    logic [SELW-1:0] out_sel_q,   out_sel_d;
    logic            out_valid_q, out_valid_d;
    logic [SELW-1:0] ptr_q,       ptr_d;

    logic [N-1:0]    grant;
    logic [SELW-1:0] grant_idx;
    logic            can_load;
    logic            any_vld;
    logic            xfer;

    rr_arbiter #(
        .N        (N),
        .ARB_MODE (ARB_MODE),
        .SELW     (SELW)
    ) u_arb (
        .req       (in_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Handshake: the output slot is free when empty or being drained this cycle.
    // in_ready is held at zero during reset so nothing is accepted mid-reset.
    always_comb begin
        can_load = !out_valid_q || out_ready;
        any_vld  = |in_valid;
        xfer     = can_load && any_vld;
        in_ready = (rst_n && xfer) ? grant : '0;
    end

    // Next-state for the output register and the round-robin pointer.
    always_comb begin
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_data_d  = in_data[int'(grant_idx)*W +: W];
            out_sel_d   = grant_idx;
            out_valid_d = 1'b1;
            if (ARB_MODE == ARB_RR) begin
                // Wrap by N rather than 2^SELW so non-power-of-two N stays in range.
                ptr_d = (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + SELW'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset discards any in-flight beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule
